// File: rtl/opb_register_ppc2simulink_commit.sv
// OPB slave register, PPC-to-fabric: staged 32-bit write, commit to user bus with valid strobe,
// commit counter and optional auto-commit on every stage write.
module opb_register_ppc2simulink_commit #(
    parameter logic [31:0] C_BASEADDR    = 32'h01080100,
    parameter logic [31:0] C_HIGHADDR    = 32'h010801FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter              C_FAMILY      = "virtex5",
    parameter logic [31:0] C_RESET_VALUE = 32'h00000000
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    output logic [0:31] Sl_DBus,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    output logic        Sl_xferAck,
    input  logic [0:31] OPB_ABus,
    input  logic [0:3]  OPB_BE,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_RNW,
    input  logic        OPB_select,
    input  logic        OPB_seqAddr,
    output logic [31:0] user_data_out,
    output logic        user_data_valid
);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

    state_t                  state;
    logic [C_OPB_AWIDTH-1:0] addr;
    logic [C_OPB_DWIDTH-1:0] wdata;
    logic [3:0]              be;
    logic [1:0]              offset;
    logic                    hit;
    logic                    write;
    logic [31:0]             stage;
    logic [31:0]             merged;
    logic [31:0]             rd_val;
    logic [31:0]             dbus_q;
    logic                    xfer_ack;
    logic [15:0]             commit_count;
    logic                    auto_en;
    logic                    commit_req;
    logic [31:0]             commit_val;
    logic [$bits(C_FAMILY):0] unused_ok;

    // OPB bit 0 is the MSB, so positional assignment maps the big-endian bus onto [31:0]
    assign addr   = OPB_ABus;
    assign wdata  = OPB_DBus;
    assign be     = OPB_BE;
    assign offset = addr[3:2];

    assign unused_ok  = {C_FAMILY, OPB_seqAddr};
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign Sl_xferAck = xfer_ack;
    assign Sl_DBus    = dbus_q;

    always_comb begin
        hit    = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
        write  = hit && !OPB_RNW && (state == S_IDLE);
        merged = stage;
        for (int unsigned j = 0; j < 4; j++) begin
            if (be[j]) merged[8*j +: 8] = wdata[8*j +: 8];
        end
        case (offset)
            2'd0:    rd_val = stage;
            2'd1:    rd_val = {commit_count, 14'b0, auto_en, 1'b0};
            2'd2:    rd_val = user_data_out;
            default: rd_val = '0;
        endcase
        // CTRL commits the pre-existing stage; auto-commit uses the freshly merged stage
        commit_req = write && (((offset == 2'd0) && auto_en) ||
                               ((offset == 2'd1) && be[0] && wdata[0]));
        commit_val = (offset == 2'd0) ? merged : stage;
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state           <= S_IDLE;
            xfer_ack        <= 1'b0;
            dbus_q          <= '0;
            stage           <= C_RESET_VALUE;
            user_data_out   <= C_RESET_VALUE;
            user_data_valid <= 1'b0;
            commit_count    <= '0;
            auto_en         <= 1'b0;
        end else begin
            xfer_ack        <= 1'b0;
            dbus_q          <= '0;
            user_data_valid <= 1'b0;
            case (state)
                S_IDLE: if (hit) begin
                    state    <= S_ACK;
                    xfer_ack <= 1'b1;
                    dbus_q   <= OPB_RNW ? rd_val : '0;
                end
                S_ACK:  state <= S_WAIT;
                S_WAIT: if (!OPB_select) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (write && (offset == 2'd0)) stage <= merged;
            if (write && (offset == 2'd1) && be[0]) auto_en <= wdata[1];
            if (commit_req) begin
                user_data_out   <= commit_val;
                user_data_valid <= 1'b1;
                commit_count    <= commit_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_opb_register_ppc2simulink_commit.sv
// Directed table-driven bench for opb_register_ppc2simulink_commit plus hand sequences
// for held select, counter wrap and reset during an acknowledge.
module tb_opb_register_ppc2simulink_commit;

    localparam logic [31:0] B     = 32'h01080100;
    localparam logic [31:0] STG   = B;
    localparam logic [31:0] CTL   = B + 32'h4;
    localparam logic [31:0] LIV   = B + 32'h8;
    localparam logic [31:0] RSV   = B + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:31] sl_dbus;
    logic        sl_err, sl_retry, sl_tout, sl_ack;
    logic [0:31] abus = '0;
    logic [0:3]  be_in = '0;
    logic [0:31] dbus = '0;
    logic        rnw = 1'b1;
    logic        sel = 1'b0;
    logic        seq = 1'b0;
    logic [31:0] udo;
    logic        uvalid;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int ack_total = 0;
    int dbus_leak = 0;

    always #5 clk = ~clk;

    opb_register_ppc2simulink_commit #(
        .C_BASEADDR   (32'h01080100),
        .C_HIGHADDR   (32'h010801FF),
        .C_RESET_VALUE(32'h00000000)
    ) dut (
        .OPB_Clk        (clk),
        .OPB_Rst        (rst),
        .Sl_DBus        (sl_dbus),
        .Sl_errAck      (sl_err),
        .Sl_retry       (sl_retry),
        .Sl_toutSup     (sl_tout),
        .Sl_xferAck     (sl_ack),
        .OPB_ABus       (abus),
        .OPB_BE         (be_in),
        .OPB_DBus       (dbus),
        .OPB_RNW        (rnw),
        .OPB_select     (sel),
        .OPB_seqAddr    (seq),
        .user_data_out  (udo),
        .user_data_valid(uvalid)
    );

    always @(negedge clk) begin
        if (uvalid) pulses++;
        if (sl_ack) ack_total++;
        if (!sl_ack && sl_dbus !== 32'h0) dbus_leak++;
    end

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        rnw;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_ack;
        logic [31:0] exp_rd;
        logic [31:0] exp_udo;
        int          exp_pulses;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic [31:0] a, input logic r, input logic [3:0] b,
                       input logic [31:0] w, input logic ea, input logic [31:0] er,
                       input logic [31:0] eu, input int ep);
        vec_t v;
        v.name = n; v.addr = a; v.rnw = r; v.be = b; v.wdata = w;
        v.exp_ack = ea; v.exp_rd = er; v.exp_udo = eu; v.exp_pulses = ep;
        vecs.push_back(v);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic r, input logic [3:0] b,
                        input logic [31:0] w, output logic acked, output logic [31:0] rd,
                        output int lat);
        @(negedge clk);
        abus = a; rnw = r; be_in = b; dbus = w; sel = 1'b1;
        acked = 1'b0; rd = '0; lat = 0;
        for (int c = 1; c <= 6 && !acked; c++) begin
            @(posedge clk); #1;
            if (sl_ack) begin
                acked = 1'b1;
                rd    = sl_dbus;
                lat   = c;
            end
        end
        sel = 1'b0; rnw = 1'b1; dbus = '0; be_in = '0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic        acked;
        logic [31:0] rd;
        int          lat;
        int          p0;
        int          a0;

        // name, addr, rnw, be, wdata, exp_ack, exp_rd, exp_udo, exp_pulses
        add("rd_stage0",   STG, 1, 4'hF, 32'h0,        1, 32'h00000000, 32'h00000000, 0);
        add("rd_status0",  CTL, 1, 4'hF, 32'h0,        1, 32'h00000000, 32'h00000000, 0);
        add("rd_live0",    LIV, 1, 4'hF, 32'h0,        1, 32'h00000000, 32'h00000000, 0);
        add("wr_stage",    STG, 0, 4'hF, 32'hDEADBEEF, 1, 32'h00000000, 32'h00000000, 0);
        add("rd_live_pre", LIV, 1, 4'hF, 32'h0,        1, 32'h00000000, 32'h00000000, 0);
        add("commit1",     CTL, 0, 4'hF, 32'h00000001, 1, 32'h00000000, 32'hDEADBEEF, 1);
        add("rd_status1",  CTL, 1, 4'hF, 32'h0,        1, 32'h00010000, 32'hDEADBEEF, 0);
        add("rd_live1",    LIV, 1, 4'hF, 32'h0,        1, 32'hDEADBEEF, 32'hDEADBEEF, 0);
        add("set_auto",    CTL, 0, 4'hF, 32'h00000002, 1, 32'h00000000, 32'hDEADBEEF, 0);
        add("rd_status2",  CTL, 1, 4'hF, 32'h0,        1, 32'h00010002, 32'hDEADBEEF, 0);
        add("auto_lane1",  STG, 0, 4'h4, 32'h12345678, 1, 32'h00000000, 32'hDE34BEEF, 1);
        add("rd_status3",  CTL, 1, 4'hF, 32'h0,        1, 32'h00020002, 32'hDE34BEEF, 0);
        add("ctl_no_be3",  CTL, 0, 4'hE, 32'h00000001, 1, 32'h00000000, 32'hDE34BEEF, 0);
        add("rd_status4",  CTL, 1, 4'hF, 32'h0,        1, 32'h00020002, 32'hDE34BEEF, 0);
        add("wr_rsv",      RSV, 0, 4'hF, 32'hFFFFFFFF, 1, 32'h00000000, 32'hDE34BEEF, 0);
        add("rd_rsv",      RSV, 1, 4'hF, 32'h0,        1, 32'h00000000, 32'hDE34BEEF, 0);
        add("rd_stage1",   STG, 1, 4'hF, 32'h0,        1, 32'hDE34BEEF, 32'hDE34BEEF, 0);
        add("wr_above",    32'h01080203, 0, 4'hF, 32'h0000000F, 0, 32'h0, 32'hDE34BEEF, 0);
        add("rd_below",    32'h010800FC, 1, 4'hF, 32'h0,        0, 32'h0, 32'hDE34BEEF, 0);
        add("commit_keep", CTL, 0, 4'hF, 32'h00000003, 1, 32'h00000000, 32'hDE34BEEF, 1);
        add("commit_off",  CTL, 0, 4'hF, 32'h00000001, 1, 32'h00000000, 32'hDE34BEEF, 1);
        add("wr_noauto",   STG, 0, 4'h1, 32'hA5A5A5A5, 1, 32'h00000000, 32'hDE34BEEF, 0);
        add("rd_status5",  CTL, 1, 4'hF, 32'h0,        1, 32'h00040000, 32'hDE34BEEF, 0);
        add("rd_stage2",   STG, 1, 4'hF, 32'h0,        1, 32'hDE34BEA5, 32'hDE34BEEF, 0);
        add("commit_on",   CTL, 0, 4'hF, 32'h00000003, 1, 32'h00000000, 32'hDE34BEA5, 1);
        add("auto_lane0",  STG, 0, 4'h8, 32'h11000000, 1, 32'h00000000, 32'h1134BEA5, 1);
        add("rd_status6",  CTL, 1, 4'hF, 32'h0,        1, 32'h00060002, 32'h1134BEA5, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",   {31'b0, sl_ack}, 32'h0);
        chk("rst_dbus",  sl_dbus, 32'h0);
        chk("rst_udo",   udo, 32'h0);
        chk("rst_valid", {31'b0, uvalid}, 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            p0 = pulses;
            xfer(vecs[i].addr, vecs[i].rnw, vecs[i].be, vecs[i].wdata, acked, rd, lat);
            chk({vecs[i].name, "_ack"}, {31'b0, acked}, {31'b0, vecs[i].exp_ack});
            if (vecs[i].exp_ack) begin
                chk({vecs[i].name, "_lat"}, lat, 32'd1);
                chk({vecs[i].name, "_rd"}, rd, vecs[i].exp_rd);
            end
            chk({vecs[i].name, "_udo"}, udo, vecs[i].exp_udo);
            chk({vecs[i].name, "_pulses"}, pulses - p0, vecs[i].exp_pulses);
        end

        // select held for five cycles: one beat only
        a0 = ack_total;
        @(negedge clk);
        abus = STG; rnw = 1'b1; be_in = 4'hF; sel = 1'b1;
        repeat (5) @(posedge clk);
        #1 sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("held_sel_acks", ack_total - a0, 32'd1);

        // counter wrap from 0xFFFF
        @(negedge clk);
        force dut.commit_count = 16'hFFFF;
        #1 release dut.commit_count;
        xfer(CTL, 1, 4'hF, 32'h0, acked, rd, lat);
        chk("status_ffff", rd, 32'hFFFF0002);
        xfer(CTL, 0, 4'hF, 32'h00000003, acked, rd, lat);
        xfer(CTL, 1, 4'hF, 32'h0, acked, rd, lat);
        chk("status_wrap", rd, 32'h00000002);

        // reset during ACK of an auto-committing stage write
        @(negedge clk);
        abus = STG; rnw = 1'b0; be_in = 4'hF; dbus = 32'h0BADF00D; sel = 1'b1;
        @(posedge clk); #1;
        chk("rstack_ack_seen", {31'b0, sl_ack}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstack_ack_drop", {31'b0, sl_ack}, 32'h0);
        chk("rstack_dbus",     sl_dbus, 32'h0);
        chk("rstack_udo",      udo, 32'h0);
        chk("rstack_valid",    {31'b0, uvalid}, 32'h0);
        rst = 1'b0; sel = 1'b0; rnw = 1'b1; dbus = '0;
        a0 = ack_total;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rstack_no_late_ack", ack_total - a0, 32'd0);
        xfer(STG, 1, 4'hF, 32'h0, acked, rd, lat);
        chk("rstack_stage", rd, 32'h0);
        xfer(CTL, 1, 4'hF, 32'h0, acked, rd, lat);
        chk("rstack_status", rd, 32'h0);
        xfer(LIV, 1, 4'hF, 32'h0, acked, rd, lat);
        chk("rstack_live", rd, 32'h0);

        chk("dbus_zero_without_ack", dbus_leak, 32'd0);
        chk("tied_outputs", {29'b0, sl_err, sl_retry, sl_tout}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
